// File: rtl/wide_id_stage_pkg.sv
// Shared RV32IM decode types for the wide decode stage: opcodes, funct3 codes,
// the per-instruction info bundle and the per-lane decoder result.
package wide_id_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'b000,
        CMP_NE   = 3'b001,
        CMP_RSV2 = 3'b010,
        CMP_RSV3 = 3'b011,
        CMP_LT   = 3'b100,
        CMP_GE   = 3'b101,
        CMP_LTU  = 3'b110,
        CMP_GEU  = 3'b111
    } cmp_op_t;

    typedef enum logic [2:0] {
        MUL_MUL    = 3'b000,
        MUL_MULH   = 3'b001,
        MUL_MULHSU = 3'b010,
        MUL_MULHU  = 3'b011,
        MUL_DIV    = 3'b100,
        MUL_DIVU   = 3'b101,
        MUL_REM    = 3'b110,
        MUL_REMU   = 3'b111
    } mul_type_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS
    } alu_op_t;

    typedef enum logic {
        PRED_NOT_TAKEN = 1'b0,
        PRED_BTFN      = 1'b1
    } predict_mode_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc_curr;
        logic [XLEN-1:0] pc_next;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [REGW-1:0] rd_s;
        logic [REGW-1:0] rs1_s;
        logic [REGW-1:0] rs2_s;
        logic            has_rd;
        logic            use_rs1;
        logic            use_rs2;
        logic [XLEN-1:0] immediate;
        logic            is_load;
        logic            is_store;
        logic [3:0]      mem_mask;
        logic            is_branch;
        logic            is_jump;
        logic            is_mul;
        mul_type_t       mul_type;
        cmp_op_t         cmp_op;
        alu_op_t         alu_op;
        logic            predict_branch;
    } instruction_info_reg_t;

    typedef struct packed {
        instruction_info_reg_t info;
        logic                  illegal;
        logic                  redirect;
        logic [XLEN-1:0]       target;
    } decode_lane_out_t;

    // alt selects SUB/SRA (funct7[5]); callers qualify it for the immediate form
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] mem_mask_decode(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/wide_id_stage_decode_lane.sv
// Single-lane combinational RV32IM decoder with static branch/jump prediction.
module wide_id_stage_decode_lane
    import wide_id_stage_pkg::*;
#(
    parameter int unsigned PREDICT_MODE = 0
) (
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            lane_valid_i,
    output decode_lane_out_t lane_c
);

    localparam predict_mode_t MODE = (PREDICT_MODE != 0) ? PRED_BTFN : PRED_NOT_TAKEN;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            legal_c;
    logic            is_jal_c;
    logic            taken_c;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        lane_c   = '0;
        legal_c  = 1'b1;
        is_jal_c = 1'b0;
        taken_c  = 1'b0;

        lane_c.info.pc_curr = pc_i;
        lane_c.info.opcode  = opcode;
        lane_c.info.funct3  = funct3;
        lane_c.info.funct7  = funct7;
        lane_c.info.rd_s    = inst_i[11:7];
        lane_c.info.rs1_s   = inst_i[19:15];
        lane_c.info.rs2_s   = inst_i[24:20];
        lane_c.info.alu_op  = ALU_ADD;

        case (opcode)
            OP_LUI: begin
                lane_c.info.has_rd    = 1'b1;
                lane_c.info.immediate = imm_u;
                lane_c.info.alu_op    = ALU_PASS;
            end
            OP_AUIPC: begin
                lane_c.info.has_rd    = 1'b1;
                lane_c.info.immediate = imm_u;
            end
            OP_JAL: begin
                lane_c.info.has_rd    = 1'b1;
                lane_c.info.immediate = imm_j;
                lane_c.info.is_jump   = 1'b1;
                is_jal_c              = 1'b1;
            end
            OP_JALR: begin
                lane_c.info.has_rd    = 1'b1;
                lane_c.info.use_rs1   = 1'b1;
                lane_c.info.immediate = imm_i;
                lane_c.info.is_jump   = 1'b1;
            end
            OP_BR: begin
                lane_c.info.use_rs1   = 1'b1;
                lane_c.info.use_rs2   = 1'b1;
                lane_c.info.immediate = imm_b;
                lane_c.info.is_branch = 1'b1;
                lane_c.info.cmp_op    = cmp_op_t'(funct3);
                lane_c.info.alu_op    = ALU_SUB;
                taken_c               = (MODE == PRED_BTFN) && imm_b[31];
            end
            OP_LOAD: begin
                lane_c.info.has_rd    = 1'b1;
                lane_c.info.use_rs1   = 1'b1;
                lane_c.info.immediate = imm_i;
                lane_c.info.is_load   = 1'b1;
                lane_c.info.mem_mask  = mem_mask_decode(funct3[1:0]);
            end
            OP_STORE: begin
                lane_c.info.use_rs1   = 1'b1;
                lane_c.info.use_rs2   = 1'b1;
                lane_c.info.immediate = imm_s;
                lane_c.info.is_store  = 1'b1;
                lane_c.info.mem_mask  = mem_mask_decode(funct3[1:0]);
            end
            OP_IMM: begin
                lane_c.info.has_rd    = 1'b1;
                lane_c.info.use_rs1   = 1'b1;
                lane_c.info.immediate = imm_i;
                lane_c.info.alu_op    = alu_decode(funct3, (funct3 == F3_SR) && funct7[5]);
            end
            OP_REG: begin
                lane_c.info.has_rd  = 1'b1;
                lane_c.info.use_rs1 = 1'b1;
                lane_c.info.use_rs2 = 1'b1;
                if (funct7 == 7'b0000001) begin
                    lane_c.info.is_mul   = 1'b1;
                    lane_c.info.mul_type = mul_type_t'(funct3);
                end else begin
                    lane_c.info.alu_op = alu_decode(funct3, funct7[5]);
                end
            end
            default: legal_c = 1'b0;
        endcase

        // Invalid lanes still decode but never predict or trap
        lane_c.info.valid          = legal_c;
        lane_c.illegal             = lane_valid_i & ~legal_c;
        lane_c.redirect            = lane_valid_i & (is_jal_c | taken_c);
        lane_c.target              = pc_i + (is_jal_c ? imm_j : imm_b);
        lane_c.info.predict_branch = lane_valid_i & taken_c;
        lane_c.info.pc_next        = lane_c.redirect ? lane_c.target : pc_i + 32'd4;
    end

endmodule

// File: rtl/wide_id_stage.sv
// N-lane decode stage: per-lane decoders, younger-lane kill behind a predicted
// redirect, a two-entry (main + skid) output buffer and a registered redirect port.
module wide_id_stage
    import wide_id_stage_pkg::*;
#(
    parameter int unsigned DECODE_WIDTH = 2,
    parameter int unsigned PREDICT_MODE = 0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [XLEN-1:0]                          in_pc,
    input  logic [DECODE_WIDTH*XLEN-1:0]             in_inst,
    input  logic [DECODE_WIDTH-1:0]                  in_lane_valid,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output instruction_info_reg_t [DECODE_WIDTH-1:0] out_info,
    output logic [DECODE_WIDTH-1:0]                  out_lane_valid,
    output logic [DECODE_WIDTH-1:0]                  out_illegal,
    output logic                                     redirect_valid,
    output logic [XLEN-1:0]                          redirect_pc
);

    // Encoding chosen so out_valid = bit0 and in_ready = ~bit1 come straight off flops
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef struct packed {
        instruction_info_reg_t [DECODE_WIDTH-1:0] info;
        logic [DECODE_WIDTH-1:0]                  lane_valid;
        logic [DECODE_WIDTH-1:0]                  illegal;
    } bundle_t;

    decode_lane_out_t lane_c [DECODE_WIDTH];
    bundle_t          bundle_c;
    logic             redir_hit_c;
    logic [XLEN-1:0]  redir_pc_c;
    logic             accept_c;
    logic             pop_c;

    logic [1:0]       state_q, state_d;
    bundle_t          main_q, main_d;
    bundle_t          skid_q, skid_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
        wide_id_stage_decode_lane #(
            .PREDICT_MODE (PREDICT_MODE)
        ) u_lane (
            .inst_i       (in_inst[g*XLEN +: XLEN]),
            .pc_i         (in_pc + 32'(4 * g)),
            .lane_valid_i (in_lane_valid[g]),
            .lane_c       (lane_c[g])
        );
    end

    // First redirecting lane wins; it keeps its valid, everything younger is killed
    always_comb begin
        bundle_c    = '0;
        redir_hit_c = 1'b0;
        redir_pc_c  = '0;
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            bundle_c.info[i]       = lane_c[i].info;
            bundle_c.lane_valid[i] = in_lane_valid[i] & ~redir_hit_c;
            bundle_c.illegal[i]    = lane_c[i].illegal & ~redir_hit_c;
            if (!redir_hit_c && lane_c[i].redirect) begin
                redir_hit_c = 1'b1;
                redir_pc_c  = lane_c[i].target;
            end
        end
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept_c  = in_valid & in_ready & ~flush;
    assign pop_c     = out_valid & out_ready;

    always_comb begin
        state_d          = state_q;
        main_d           = main_q;
        skid_d           = skid_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        main_d  = bundle_c;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && pop_c) begin
                        main_d = bundle_c;
                    end else if (accept_c) begin
                        skid_d  = bundle_c;
                        state_d = ST_FULL;
                    end else if (pop_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_c) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase

            if (accept_c && redir_hit_c) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = redir_pc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_EMPTY;
            main_q           <= '0;
            skid_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            main_q           <= main_d;
            skid_q           <= skid_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_info       = main_q.info;
    assign out_lane_valid = main_q.lane_valid;
    assign out_illegal    = main_q.illegal;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_wide_id_stage.sv
// Scoreboard bench for wide_id_stage: a BTFN instance is fully checked, a
// not-taken instance on the same inputs is checked for lane kill and redirect.
module tb_wide_id_stage;
    import wide_id_stage_pkg::*;

    localparam int unsigned N = 2;

    logic                             clk;
    logic                             rst_n;
    logic                             flush;
    logic                             in_valid;
    logic                             in_ready, in_ready0;
    logic [31:0]                      in_pc;
    logic [N*32-1:0]                  in_inst;
    logic [N-1:0]                     in_lane_valid;
    logic                             out_valid, out_valid0;
    logic                             out_ready;
    instruction_info_reg_t [N-1:0]    out_info, out_info0;
    logic [N-1:0]                     out_lane_valid, out_lane_valid0;
    logic [N-1:0]                     out_illegal, out_illegal0;
    logic                             redirect_valid, redirect_valid0;
    logic [31:0]                      redirect_pc, redirect_pc0;

    wide_id_stage #(.DECODE_WIDTH(N), .PREDICT_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_lane_valid(in_lane_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info),
        .out_lane_valid(out_lane_valid), .out_illegal(out_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    wide_id_stage #(.DECODE_WIDTH(N), .PREDICT_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc(in_pc), .in_inst(in_inst), .in_lane_valid(in_lane_valid),
        .out_valid(out_valid0), .out_ready(out_ready), .out_info(out_info0),
        .out_lane_valid(out_lane_valid0), .out_illegal(out_illegal0),
        .redirect_valid(redirect_valid0), .redirect_pc(redirect_pc0)
    );

    typedef struct packed {
        logic [1:0]  lv;
        logic [1:0]  lv0;
        logic [1:0]  ill;
        logic        v0;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] imm0;
        logic [31:0] imm1;
        logic [31:0] pc0;
        logic        redir;
        logic        redir0;
        logic [31:0] rpc;
    } exp_t;

    localparam logic [31:0] I_A   = 32'h0010_0093;
    localparam logic [31:0] I_B   = 32'h0020_0113;
    localparam logic [31:0] I_BEQ = 32'hFE00_0CE3;
    localparam logic [31:0] I_JAL = 32'h0100_00EF;
    localparam logic [31:0] I_BAD = 32'hFFFF_FFFF;

    int   n_checks;
    int   n_err;
    int   cnt;
    exp_t q[$];
    exp_t cur_exp;
    logic exp_rv, exp_rv0;
    logic [31:0] exp_rpc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] lv, input logic [1:0] lv0, input logic [1:0] ill,
                                input logic v0, input logic [4:0] rd0, input logic [4:0] rd1,
                                input logic [31:0] imm0, input logic [31:0] imm1, input logic [31:0] pc0,
                                input logic redir, input logic redir0, input logic [31:0] rpc);
        exp_t e;
        e.lv = lv; e.lv0 = lv0; e.ill = ill; e.v0 = v0; e.rd0 = rd0; e.rd1 = rd1;
        e.imm0 = imm0; e.imm1 = imm1; e.pc0 = pc0; e.redir = redir; e.redir0 = redir0; e.rpc = rpc;
        return e;
    endfunction

    // Holds the bundle until the stage takes it; called right after a rising edge
    task automatic offer(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] lv, input exp_t e);
        logic acc;
        in_pc = pc; in_inst = {i1, i0}; in_lane_valid = lv; cur_exp = e; in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_checks++; n_err++;
        $display("FAIL offer_timeout: pc 0x%08h not accepted within 20 cycles", pc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference occupancy model + scoreboard pop, evaluated between edges
    always @(negedge clk) begin
        exp_t e;
        logic acc, do_pop;
        if (!rst_n) begin
            cnt = 0; q.delete(); exp_rv = 1'b0; exp_rv0 = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(cnt < 2));
            chk("out_valid", 32'(out_valid), 32'(cnt > 0));
            chk("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
            if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
            chk("redirect_valid_mode0", 32'(redirect_valid0), 32'(exp_rv0));
            if (exp_rv0) chk("redirect_pc_mode0", redirect_pc0, exp_rpc);
            do_pop = !flush && out_ready && (cnt > 0);
            if (do_pop) begin
                e = q.pop_front();
                chk("lane_valid", 32'(out_lane_valid), 32'(e.lv));
                chk("lane_valid_mode0", 32'(out_lane_valid0), 32'(e.lv0));
                chk("illegal", 32'(out_illegal), 32'(e.ill));
                chk("info0_valid", 32'(out_info[0].valid), 32'(e.v0));
                chk("rd0", 32'(out_info[0].rd_s), 32'(e.rd0));
                chk("rd1", 32'(out_info[1].rd_s), 32'(e.rd1));
                chk("imm0", out_info[0].immediate, e.imm0);
                chk("imm1", out_info[1].immediate, e.imm1);
                chk("pc0", out_info[0].pc_curr, e.pc0);
                chk("pc1", out_info[1].pc_curr, e.pc0 + 32'd4);
            end
            acc = in_valid && (cnt < 2) && !flush;
            if (flush) begin
                cnt = 0; q.delete(); exp_rv = 1'b0; exp_rv0 = 1'b0;
            end else begin
                if (acc) q.push_back(cur_exp);
                cnt = cnt + int'(acc) - int'(do_pop);
                exp_rv  = acc && cur_exp.redir;
                exp_rv0 = acc && cur_exp.redir0;
                exp_rpc = cur_exp.rpc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_err = 0; cnt = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_inst = '0; in_lane_valid = '0; cur_exp = '0;
        exp_rv = 1'b0; exp_rv0 = 1'b0; exp_rpc = '0;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_lane_valid", 32'(out_lane_valid), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_info_zero", 32'(out_info == '0), 32'd1);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Full throughput, one bundle per cycle
        for (int k = 0; k < 4; k++)
            offer(32'h1000 + 32'(8 * k), I_A, I_B, 2'b11,
                  mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'h1000 + 32'(8 * k), 1'b0, 1'b0, 32'd0));
        idle(3);

        // Backpressure: three stalled cycles, third bundle waits for space
        out_ready = 1'b0;
        offer(32'h2000, 32'h0030_0093, 32'h0040_0113, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd3, 32'd4, 32'h2000, 1'b0, 1'b0, 32'd0));
        offer(32'h2008, 32'h0050_0093, 32'h0060_0113, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd5, 32'd6, 32'h2008, 1'b0, 1'b0, 32'd0));
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        fork
            offer(32'h2010, 32'h0070_0093, 32'h0080_0113, 2'b11,
                  mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd7, 32'd8, 32'h2010, 1'b0, 1'b0, 32'd0));
            begin
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Backward branch: taken under BTFN only
        offer(32'h100, I_BEQ, I_A, 2'b11,
              mk(2'b01, 2'b11, 2'b00, 1'b1, 5'd25, 5'd1, 32'hFFFF_FFF8, 32'd1, 32'h100, 1'b1, 1'b0, 32'hF8));
        idle(2);
        // JAL in lane 1 redirects in both modes
        offer(32'h200, I_A, I_JAL, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd1, 32'd1, 32'd16, 32'h200, 1'b1, 1'b1, 32'h214));
        idle(2);
        // JAL in lane 0 kills lane 1
        offer(32'h340, I_JAL, I_A, 2'b11,
              mk(2'b01, 2'b01, 2'b00, 1'b1, 5'd1, 5'd1, 32'd16, 32'd1, 32'h340, 1'b1, 1'b1, 32'h350));
        // JAL in an invalid lane does nothing
        offer(32'h240, I_A, I_JAL, 2'b01,
              mk(2'b01, 2'b01, 2'b00, 1'b1, 5'd1, 5'd1, 32'd1, 32'd16, 32'h240, 1'b0, 1'b0, 32'd0));
        // Illegal opcode in a valid lane
        offer(32'h280, I_BAD, I_B, 2'b11,
              mk(2'b11, 2'b11, 2'b01, 1'b0, 5'd31, 5'd2, 32'd0, 32'd2, 32'h280, 1'b0, 1'b0, 32'd0));
        // Illegal opcode in an invalid lane is not flagged
        offer(32'h2C0, I_A, I_BAD, 2'b01,
              mk(2'b01, 2'b01, 2'b00, 1'b1, 5'd1, 5'd31, 32'd1, 32'd0, 32'h2C0, 1'b0, 1'b0, 32'd0));
        // All lanes invalid: still forwarded
        offer(32'h300, I_JAL, I_A, 2'b00,
              mk(2'b00, 2'b00, 2'b00, 1'b1, 5'd1, 5'd1, 32'd16, 32'd1, 32'h300, 1'b0, 1'b0, 32'd0));
        idle(3);

        // Flush while full, with a redirecting bundle offered on the same edge
        out_ready = 1'b0;
        offer(32'h3000, I_A, I_B, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'h3000, 1'b0, 1'b0, 32'd0));
        offer(32'h3008, I_A, I_B, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'h3008, 1'b0, 1'b0, 32'd0));
        in_pc = 32'h3010; in_inst = {I_A, I_JAL}; in_lane_valid = 2'b11;
        cur_exp = mk(2'b01, 2'b01, 2'b00, 1'b1, 5'd1, 5'd1, 32'd16, 32'd1, 32'h3010, 1'b1, 1'b1, 32'h3020);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_redirect", 32'(redirect_valid), 32'd0);
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset while full with a redirect pending
        out_ready = 1'b0;
        offer(32'h4000, I_A, I_B, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'h4000, 1'b0, 1'b0, 32'd0));
        offer(32'h400, I_A, I_JAL, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd1, 32'd1, 32'd16, 32'h400, 1'b1, 1'b1, 32'h414));
        chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
        chk("pre_rst_redirect_pc", redirect_pc, 32'h414);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_redirect", 32'(redirect_valid), 32'd0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        offer(32'h5000, I_A, I_B, 2'b11,
              mk(2'b11, 2'b11, 2'b00, 1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'h5000, 1'b0, 1'b0, 32'd0));
        idle(4);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
